// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, polynomials and GF(2) mask generator for the lfsr step engine
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIBONACCI,
        LFSR_GALOIS
    } lfsr_cfg_e;

    // 10GBASE-R self-synchronous scrambler, x^58 + x^39 + 1
    localparam logic [57:0] SCRAMBLER_POLY_58 = 58'h8000000001;
    // PRBS31 generator, x^31 + x^28 + 1
    localparam logic [30:0] PRBS31_POLY       = 31'h10000001;

    // Upper bounds for the elaboration-time walk; real widths are passed in.
    localparam int LFSR_MAX_W = 128;
    localparam int DATA_MAX_W = 128;

    typedef logic [LFSR_MAX_W-1:0] lfsr_vec_t;
    typedef logic [DATA_MAX_W-1:0] data_vec_t;

    typedef struct packed {
        data_vec_t data;
        lfsr_vec_t state;
    } lfsr_resp_t;

    // Runs data_w single-bit steps on concrete vectors. The whole engine is
    // linear over GF(2), so driving a unit vector on one input bit returns
    // that input's column of the transfer matrix (which outputs it toggles).
    function automatic lfsr_resp_t lfsr_mask_col(
        input int        lfsr_w,
        input lfsr_vec_t poly,
        input lfsr_cfg_e cfg,
        input logic      feed_forward,
        input int        data_w,
        input lfsr_vec_t state_in,
        input data_vec_t data_in
    );
        lfsr_vec_t  s;
        lfsr_vec_t  wmask;
        lfsr_vec_t  taps;
        data_vec_t  acc;
        logic       fb;
        logic       d;
        logic       shift_in;
        lfsr_resp_t r;

        wmask = '0;
        wmask = ~(~wmask << lfsr_w);
        // bit 0 of the polynomial is the implicit +1 term, never a tap
        taps    = poly & wmask;
        taps[0] = 1'b0;
        s       = state_in & wmask;
        acc     = '0;

        for (int i = data_w - 1; i >= 0; i--) begin
            d = data_in[i];
            if (cfg == LFSR_FIBONACCI) begin
                // tap x^j reads the state bit j-1
                fb       = s[lfsr_w-1] ^ d ^ (^(s & (taps >> 1)));
                shift_in = feed_forward ? d : fb;
                s        = (s << 1) & wmask;
                s[0]     = shift_in;
            end else begin
                fb       = s[lfsr_w-1] ^ d;
                shift_in = feed_forward ? d : fb;
                s        = (s << 1) & wmask;
                s[0]     = shift_in;
                if (shift_in) begin
                    s = s ^ taps;
                end
            end
            acc    = acc << 1;
            acc[0] = fb;
        end

        r.data  = acc;
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - parallel LFSR step engine advancing DATA_W bit-steps per evaluation (optional output register: LFSR_OUT_REG_EN)
module lfsr #(
    parameter int                LFSR_W            = 31,
    parameter logic [LFSR_W-1:0] LFSR_POLY         = 31'h10000001,
    parameter int                LFSR_GALOIS       = 0,
    parameter int                LFSR_FEED_FORWARD = 0,
    parameter int                REVERSE           = 0,
    parameter int                DATA_W            = 8,
    parameter int                DATA_IN_EN        = 1,
    parameter int                DATA_OUT_EN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LFSR_W-1:0] state_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LFSR_W-1:0] state_out
);
    import lfsr_pkg::*;

    localparam int NIN  = LFSR_W + DATA_W;
    localparam int NOUT = LFSR_W + DATA_W;

    localparam lfsr_cfg_e CFG = (LFSR_GALOIS != 0) ? lfsr_pkg::LFSR_GALOIS
                                                   : lfsr_pkg::LFSR_FIBONACCI;

    // Row o selects the inputs {data, state} whose XOR forms output o
    // (rows 0..LFSR_W-1 are state_out, the rest data_out).
    typedef logic [NOUT-1:0][NIN-1:0] mask_mat_t;

    function automatic mask_mat_t build_masks();
        mask_mat_t  m;
        lfsr_resp_t r;
        lfsr_vec_t  s;
        data_vec_t  d;
        m = '0;
        for (int b = 0; b < NIN; b++) begin
            s = '0;
            d = '0;
            if (b < LFSR_W) begin
                s[b] = 1'b1;
            end else if (DATA_IN_EN != 0) begin
                d[b-LFSR_W] = 1'b1;
            end
            r = lfsr_mask_col(LFSR_W, lfsr_vec_t'(LFSR_POLY), CFG,
                              LFSR_FEED_FORWARD != 0, DATA_W, s, d);
            for (int o = 0; o < LFSR_W; o++) begin
                m[o][b] = r.state[o];
            end
            for (int o = 0; o < DATA_W; o++) begin
                m[LFSR_W+o][b] = r.data[o];
            end
        end
        return m;
    endfunction

    localparam mask_mat_t MASKS = build_masks();

    // Normal-order views of the boundary signals
    logic [LFSR_W-1:0] state_n;
    logic [DATA_W-1:0] data_n;
    logic [LFSR_W-1:0] state_raw;
    logic [DATA_W-1:0] data_raw;
    logic [LFSR_W-1:0] state_c;
    logic [DATA_W-1:0] data_c;
    logic [NIN-1:0]    in_vec;

    // REVERSE turns the engine LSB-first by mirroring every boundary word
    for (genvar k = 0; k < LFSR_W; k++) begin : g_state_io
        if (REVERSE != 0) begin : g_rev
            assign state_n[k] = state_in[LFSR_W-1-k];
            assign state_c[k] = state_raw[LFSR_W-1-k];
        end else begin : g_fwd
            assign state_n[k] = state_in[k];
            assign state_c[k] = state_raw[k];
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_data_io
        if (REVERSE != 0) begin : g_rev
            assign data_n[k] = data_in[DATA_W-1-k];
            assign data_c[k] = data_raw[DATA_W-1-k];
        end else begin : g_fwd
            assign data_n[k] = data_in[k];
            assign data_c[k] = data_raw[k];
        end
    end

    assign in_vec = {data_n, state_n};

    // Each output is a fixed XOR of the selected inputs
    for (genvar o = 0; o < LFSR_W; o++) begin : g_state_row
        assign state_raw[o] = ^(in_vec & MASKS[o]);
    end

    if (DATA_OUT_EN != 0) begin : g_dout
        for (genvar o = 0; o < DATA_W; o++) begin : g_data_row
            assign data_raw[o] = ^(in_vec & MASKS[LFSR_W+o]);
        end
    end else begin : g_no_dout
        assign data_raw = '0;
    end

`ifdef LFSR_OUT_REG_EN
    // Register both outputs; reset clears them and wins over new data
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            state_out <= '0;
        end else begin
            data_out  <= data_c;
            state_out <= state_c;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign data_out       = data_c;
    assign state_out      = state_c;
`endif

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - self-checking bench for the lfsr step engine
module tb_lfsr;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Small W=4, x^4+x+1, one-bit instances sharing their inputs
    logic [3:0] t_state = 4'b0000;
    logic       t_data  = 1'b0;
    logic [3:0] so  [6];
    logic       do1 [6];
    string      names [6] = '{"fib_noin", "fib", "fib_nodout", "ff", "gal", "rev"};

    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1), .DATA_IN_EN(0)) u_fib_noin (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[0]), .state_out(so[0]));
    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1)) u_fib (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[1]), .state_out(so[1]));
    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1), .DATA_OUT_EN(0)) u_fib_nodout (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[2]), .state_out(so[2]));
    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1), .LFSR_FEED_FORWARD(1)) u_ff (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[3]), .state_out(so[3]));
    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1), .LFSR_GALOIS(1)) u_gal (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[4]), .state_out(so[4]));
    lfsr #(.LFSR_W(4), .LFSR_POLY(4'h3), .DATA_W(1), .REVERSE(1)) u_rev (
        .clk(clk), .rst(rst), .data_in(t_data), .state_in(t_state), .data_out(do1[5]), .state_out(so[5]));

    // 10GBASE-R scrambler / descrambler pair, LSB first
    logic [57:0] scr_st = '0, dsc_st = '0, scr_sout, dsc_sout;
    logic [63:0] scr_din = '0, dsc_din = '0, scr_dout, dsc_dout;

    lfsr #(.LFSR_W(58), .LFSR_POLY(SCRAMBLER_POLY_58), .DATA_W(64), .REVERSE(1)) u_scr (
        .clk(clk), .rst(rst), .data_in(scr_din), .state_in(scr_st), .data_out(scr_dout), .state_out(scr_sout));
    lfsr #(.LFSR_W(58), .LFSR_POLY(SCRAMBLER_POLY_58), .DATA_W(64), .REVERSE(1), .LFSR_FEED_FORWARD(1)) u_dsc (
        .clk(clk), .rst(rst), .data_in(dsc_din), .state_in(dsc_st), .data_out(dsc_dout), .state_out(dsc_sout));

    // PRBS31 with default parameters (Fibonacci) and a Galois variant
    logic [30:0] p_st = '0, p_sout, g_st = '0, g_sout;
    logic [7:0]  p_din = '0, p_dout, g_din = '0, g_dout;

    lfsr u_prbs (
        .clk(clk), .rst(rst), .data_in(p_din), .state_in(p_st), .data_out(p_dout), .state_out(p_sout));
    lfsr #(.LFSR_W(31), .LFSR_POLY(PRBS31_POLY), .DATA_W(8), .LFSR_GALOIS(1)) u_gal31 (
        .clk(clk), .rst(rst), .data_in(g_din), .state_in(g_st), .data_out(g_dout), .state_out(g_sout));

    typedef struct {
        int         sel;
        logic [3:0] st;
        logic       d;
        logic [3:0] exp_st;
        logic       exp_d;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input int sel, input logic [3:0] st, input logic d,
                           input logic [3:0] es, input logic ed);
        vec_t v;
        v.sel = sel; v.st = st; v.d = d; v.exp_st = es; v.exp_d = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait until the outputs reflect the current inputs
    task automatic settle();
`ifdef LFSR_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    localparam logic [63:0] SYNC_MASK = 64'hFC00_0000_0000_0000;
    localparam logic [30:0] GAL_POLY  = PRBS31_POLY | 31'd1;

    initial begin
        bit         hist[$];
        bit         phist[$];
        bit         b;
        bit         fb;
        logic [63:0] exp_d64;
        logic [57:0] exp_s58;
        logic [7:0]  exp_d8;
        logic [30:0] exp_s31;
        logic [30:0] gm;

        // ---------------- reset / latency behaviour ----------------
        @(negedge clk);
`ifdef LFSR_OUT_REG_EN
        t_state = 4'b0001; t_data = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("reg_rst_state", 64'(so[1]), 64'h0);
        check("reg_rst_data", 64'(do1[1]), 64'h0);
        check("reg_rst_scr_state", 64'(scr_sout), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reg_hold_state", 64'(so[1]), 64'h0);
        @(posedge clk); #1;
        check("reg_lat_state", 64'(so[1]), 64'h3);
        check("reg_lat_data", 64'(do1[1]), 64'h1);
        t_state = 4'b1000;
        #1;
        check("reg_lat_hold", 64'(so[1]), 64'h3);
        @(posedge clk); #1;
        check("reg_lat_state2", 64'(so[1]), 64'h1);
        rst = 1'b1; t_state = 4'b0001;
        @(posedge clk); #1;
        check("reg_rst_prio_state", 64'(so[1]), 64'h0);
        check("reg_rst_prio_data", 64'(do1[1]), 64'h0);
        rst = 1'b0;
`else
        rst = 1'b1; t_state = 4'b0001; t_data = 1'b0;
        #1;
        check("comb_state", 64'(so[1]), 64'h3);
        check("comb_data", 64'(do1[1]), 64'h1);
        @(posedge clk); #1;
        check("comb_rst_ignored", 64'(so[1]), 64'h3);
        t_state = 4'b1000;
        #1;
        check("comb_zero_latency", 64'(so[1]), 64'h1);
        rst = 1'b0;
`endif

        // ---------------- table-driven single-step vectors ----------------
        add_vec(0, 4'b0001, 1'b1, 4'b0011, 1'b1);
        add_vec(0, 4'b1000, 1'b0, 4'b0001, 1'b1);
        add_vec(0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        add_vec(1, 4'b0000, 1'b1, 4'b0001, 1'b1);
        add_vec(1, 4'b0001, 1'b1, 4'b0010, 1'b0);
        add_vec(1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        add_vec(2, 4'b0000, 1'b1, 4'b0001, 1'b0);
        add_vec(2, 4'b1000, 1'b0, 4'b0001, 1'b0);
        add_vec(3, 4'b0001, 1'b0, 4'b0010, 1'b1);
        add_vec(3, 4'b0001, 1'b1, 4'b0011, 1'b0);
        add_vec(4, 4'b1000, 1'b0, 4'b0011, 1'b1);
        add_vec(4, 4'b0101, 1'b1, 4'b1001, 1'b1);
        add_vec(4, 4'b0100, 1'b0, 4'b1000, 1'b0);
        add_vec(4, 4'b0000, 1'b0, 4'b0000, 1'b0);
        add_vec(5, 4'b1000, 1'b0, 4'b1100, 1'b1);
        add_vec(5, 4'b0001, 1'b0, 4'b1000, 1'b1);
        add_vec(5, 4'b0000, 1'b1, 4'b1000, 1'b1);

        foreach (vecs[i]) begin
            t_state = vecs[i].st;
            t_data  = vecs[i].d;
            settle();
            check($sformatf("%s_state[%0d]", names[vecs[i].sel], i),
                  64'(so[vecs[i].sel]), 64'(vecs[i].exp_st));
            check($sformatf("%s_data[%0d]", names[vecs[i].sel], i),
                  64'(do1[vecs[i].sel]), 64'(vecs[i].exp_d));
        end

        // ---------------- scrambler + descrambler, 1000 random words ----------------
        // Model: scrambled bit b_n = d_n ^ b_{n-39} ^ b_{n-58}; hist[k] = b_{n-1-k}
        scr_st = 58'({$urandom, $urandom});
        dsc_st = 58'({$urandom, $urandom});
        for (int k = 0; k < 58; k++) hist.push_back(scr_st[57-k]);

        for (int w = 0; w < 1000; w++) begin
            scr_din = {$urandom, $urandom};
            for (int k = 0; k < 64; k++) begin
                b = scr_din[k] ^ hist[38] ^ hist[57];
                exp_d64[k] = b;
                hist.push_front(b);
                void'(hist.pop_back());
            end
            for (int k = 0; k < 58; k++) exp_s58[57-k] = hist[k];

            settle();
            check($sformatf("scr_data[%0d]", w), scr_dout, exp_d64);
            check($sformatf("scr_state[%0d]", w), 64'(scr_sout), 64'(exp_s58));

            dsc_din = exp_d64;
            settle();
            if (w == 0)
                check("dsc_sync_data[0]", dsc_dout & SYNC_MASK, scr_din & SYNC_MASK);
            else
                check($sformatf("dsc_data[%0d]", w), dsc_dout, scr_din);
            check($sformatf("dsc_state[%0d]", w), 64'(dsc_sout), 64'(exp_s58));

            scr_st = scr_sout;
            dsc_st = dsc_sout;
        end

        // ---------------- PRBS31 Fibonacci (defaults) and Galois, 200 words ----------------
        p_st = 31'($urandom);
        g_st = 31'($urandom);
        gm   = g_st;
        for (int k = 0; k < 31; k++) phist.push_back(p_st[k]);

        for (int w = 0; w < 200; w++) begin
            p_din = 8'($urandom);
            g_din = (w < 20) ? 8'h00 : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                b = p_din[i] ^ phist[27] ^ phist[30];
                exp_d8[i] = b;
                phist.push_front(b);
                void'(phist.pop_back());
            end
            for (int k = 0; k < 31; k++) exp_s31[k] = phist[k];

            settle();
            check($sformatf("prbs_data[%0d]", w), 64'(p_dout), 64'(exp_d8));
            check($sformatf("prbs_state[%0d]", w), 64'(p_sout), 64'(exp_s31));

            // Galois: multiply state by x modulo the polynomial, input folded into feedback
            for (int i = 7; i >= 0; i--) begin
                fb = gm[30] ^ g_din[i];
                gm = {gm[29:0], 1'b0} ^ (fb ? GAL_POLY : 31'd0);
                exp_d8[i] = fb;
            end
            check($sformatf("gal31_data[%0d]", w), 64'(g_dout), 64'(exp_d8));
            check($sformatf("gal31_state[%0d]", w), 64'(g_sout), 64'(gm));

            p_st = p_sout;
            g_st = g_sout;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
